// File: rtl/branch_pc_sequencer_pkg.sv
// Shared definitions for the PC sequencer: branch condition codes, FSM states
// and the width of the post-redirect bubble counter.
package branch_pc_sequencer_pkg;

    localparam logic [2:0] Funct3Beq  = 3'b000;
    localparam logic [2:0] Funct3Bne  = 3'b001;
    localparam logic [2:0] Funct3Blt  = 3'b100;
    localparam logic [2:0] Funct3Bge  = 3'b101;
    localparam logic [2:0] Funct3Bltu = 3'b110;
    localparam logic [2:0] Funct3Bgeu = 3'b111;

    // Holds FLUSH_CYCLES, which is limited to 1..7.
    localparam int unsigned BubW = 3;

    typedef enum logic [1:0] {
        StBoot,
        StRun,
        StFlush
    } state_e;

    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/branch_cond_eval.sv
// Combinational branch-condition evaluation from funct3 and the ALU compare flags.
module branch_cond_eval
    import branch_pc_sequencer_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       lt,
    input  logic       ltu,
    output logic       cond
);

    always_comb begin
        cond = 1'b0;
        case (funct3)
            Funct3Beq:  cond = zero;
            Funct3Bne:  cond = ~zero;
            Funct3Blt:  cond = lt;
            Funct3Bge:  cond = ~lt;
            Funct3Bltu: cond = ltu;
            Funct3Bgeu: cond = ~ltu;
            // 010/011 are not branch encodings and never redirect.
            default:    cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_pc_sequencer.sv
// Program counter owner: accepts EX redirects, inserts flush bubbles after each
// taken redirect and tracks redirect statistics / misaligned targets.
module branch_pc_sequencer
    import branch_pc_sequencer_pkg::*;
#(
    parameter logic [31:0] RESET_PC     = 32'h0000_0000,
    parameter int unsigned FLUSH_CYCLES = 2,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ex_valid,
    input  logic             force_jump,
    input  logic             branch,
    input  logic [2:0]       funct3,
    input  logic             zero,
    input  logic             lt,
    input  logic             ltu,
    input  logic [31:0]      target,
    input  logic             stall,
    output logic [31:0]      pc,
    output logic             fetch_valid,
    output logic             flush,
    output logic             taken,
    output logic             misalign_err,
    output logic [CNT_W-1:0] taken_cnt
);

    state_e            state_q, state_d;
    logic [31:0]       pc_q, pc_d;
    logic [BubW-1:0]   bub_q, bub_d;
    logic              taken_q, taken_d;
    logic              mis_q, mis_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              cond;
    logic              take;

    branch_cond_eval u_cond (
        .funct3 (funct3),
        .zero   (zero),
        .lt     (lt),
        .ltu    (ltu),
        .cond   (cond)
    );

    // Only RUN accepts redirects; EX is on the wrong path while flushing.
    assign take = ex_valid & (force_jump | (branch & cond)) & (state_q == StRun);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StBoot;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StBoot:  state_d = StRun;
            StRun:   if (take) state_d = StFlush;
            StFlush: if (!stall && bub_q == BubW'(1)) state_d = StRun;
            default: state_d = StBoot;
        endcase
    end

    always_comb begin
        fetch_valid = (state_q != StBoot);
        flush       = (state_q == StFlush);
    end

    // Datapath: a redirect wins over stall; otherwise the PC advances on unstalled cycles.
    always_comb begin
        pc_d    = pc_q;
        bub_d   = bub_q;
        taken_d = 1'b0;
        mis_d   = mis_q;
        cnt_d   = cnt_q;
        if (take) begin
            pc_d    = word_align(target);
            bub_d   = BubW'(FLUSH_CYCLES);
            taken_d = 1'b1;
            mis_d   = mis_q | (target[1:0] != 2'b00);
            if (cnt_q != {CNT_W{1'b1}}) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (state_q != StBoot && !stall) begin
            pc_d = pc_q + 32'd4;
            if (state_q == StFlush) begin
                bub_d = bub_q - BubW'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q    <= RESET_PC;
            bub_q   <= '0;
            taken_q <= 1'b0;
            mis_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            pc_q    <= pc_d;
            bub_q   <= bub_d;
            taken_q <= taken_d;
            mis_q   <= mis_d;
            cnt_q   <= cnt_d;
        end
    end

    assign pc           = pc_q;
    assign taken        = taken_q;
    assign misalign_err = mis_q;
    assign taken_cnt    = cnt_q;

endmodule
